// File: rtl/arm32_pkg.sv
// Shared ARM32 definitions: condition-code encodings and NZCV bit positions.
package arm32_pkg;

    // ARM condition field encodings
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Bit positions within the packed {N,Z,C,V} flag vector
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/arm32_cond_eval.sv
// Combinational ARM32 condition-code evaluator: decides whether an instruction
// with condition field cond executes given the architectural NZCV flags.
module arm32_cond_eval
    import arm32_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    // Decode the condition field against the current flags
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm32_cond_flags_stage.sv
// EX->WB pipeline stage: registers ALU result/destination behind a valid/ready
// handshake, evaluates the condition code on the current NZCV flags and updates
// the flags on executed S-instructions. Defining ARM32_COND_STATS_EN adds
// saturating executed/skipped instruction counters (stat_exec, stat_skip).
module arm32_cond_flags_stage
    import arm32_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
`ifdef ARM32_COND_STATS_EN
    parameter int unsigned CNT_W     = 16,
`endif
    parameter logic [3:0]  FLAGS_RST = 4'b0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_cond,
    input  logic              in_s,
    input  logic              in_wb,
    input  logic [3:0]        in_rd,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [3:0]        alu_nzcv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        out_rd,
    output logic              out_wr_en,
`ifdef ARM32_COND_STATS_EN
    output logic [CNT_W-1:0]  stat_exec,
    output logic [CNT_W-1:0]  stat_skip,
`endif
    output logic [3:0]        flags,
    output logic              alu_cin
);

    logic              cond_pass;
    logic              xfer;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [3:0]        out_rd_q, out_rd_d;
    logic              out_wr_en_q, out_wr_en_d;
    logic [3:0]        flags_q, flags_d;

    // Condition is judged on the pre-update flags; the update lands on the same edge
    arm32_cond_eval u_cond_eval (
        .cond (in_cond),
        .nzcv (flags_q),
        .pass (cond_pass)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign xfer     = in_valid && in_ready && !flush;

    // Next-state for the output slot and the architectural flags
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_rd_d    = out_rd_q;
        out_wr_en_d = out_wr_en_q;
        flags_d     = flags_q;

        if (flush) begin
            // Kill the held instruction; payload is left stale
            out_valid_d = 1'b0;
        end else if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = alu_out;
            out_rd_d    = in_rd;
            out_wr_en_d = in_wb && cond_pass;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (xfer && cond_pass && in_s) begin
            flags_d = alu_nzcv;
        end
    end

    // Stage and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_rd_q    <= '0;
            out_wr_en_q <= 1'b0;
            flags_q     <= FLAGS_RST;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_rd_q    <= out_rd_d;
            out_wr_en_q <= out_wr_en_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_rd    = out_rd_q;
    assign out_wr_en = out_wr_en_q;
    assign flags     = flags_q;
    assign alu_cin   = flags_q[FLAG_C];

`ifdef ARM32_COND_STATS_EN
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [CNT_W-1:0] stat_exec_q, stat_exec_d;
    logic [CNT_W-1:0] stat_skip_q, stat_skip_d;

    // Saturating counts of executed and condition-failed transfers
    always_comb begin
        stat_exec_d = stat_exec_q;
        stat_skip_d = stat_skip_q;
        if (xfer && cond_pass && (stat_exec_q != CntMax)) begin
            stat_exec_d = stat_exec_q + CNT_W'(1);
        end
        if (xfer && !cond_pass && (stat_skip_q != CntMax)) begin
            stat_skip_d = stat_skip_q + CNT_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_exec_q <= '0;
            stat_skip_q <= '0;
        end else begin
            stat_exec_q <= stat_exec_d;
            stat_skip_q <= stat_skip_d;
        end
    end

    assign stat_exec = stat_exec_q;
    assign stat_skip = stat_skip_q;
`endif

endmodule
